// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one iterative single-precision multiplier by two requesters.
// Define FP_MUL_ARB_ZERO_BYPASS_EN to answer zero-operand products without using the multiplier.
module fp_mul_arbiter #(
   parameter int unsigned LATENCY = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_result,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_result,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_clear,
   input  logic [31:0] mul_result
);
   // state | meaning
   // IDLE  | no operation in flight, may accept one operand pair
   // LOAD  | one cycle with mul_clear high, operands already on mul_a/mul_b
   // RUN   | multiplier iterating; result returned to owner on the last count
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] mul_a_q, mul_a_d;
   logic [31:0] mul_b_q, mul_b_d;
   logic        mul_clear_q, mul_clear_d;
   logic        rsp0_valid_q, rsp0_valid_d;
   logic        rsp1_valid_q, rsp1_valid_d;
   logic [31:0] rsp0_result_q, rsp0_result_d;
   logic [31:0] rsp1_result_q, rsp1_result_d;

   logic        grant0, grant1, acc, acc_id, acc_zero;
   logic [31:0] acc_a, acc_b;

   // Ties go to the requester that was not served last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE) begin
         grant0 = req0_valid && (!req1_valid || last_grant_q);
         grant1 = req1_valid && (!req0_valid || !last_grant_q);
      end
      acc    = grant0 || grant1;
      acc_id = grant1;
      acc_a  = grant1 ? req1_a : req0_a;
      acc_b  = grant1 ? req1_b : req0_b;
`ifdef FP_MUL_ARB_ZERO_BYPASS_EN
      acc_zero = (acc_a[30:0] == 31'd0) || (acc_b[30:0] == 31'd0);
`else
      acc_zero = 1'b0;
`endif
   end

   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp1_result = rsp1_result_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign mul_clear   = mul_clear_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      mul_clear_d   = 1'b0;
      rsp0_valid_d  = 1'b0;
      rsp1_valid_d  = 1'b0;
      rsp0_result_d = rsp0_result_q;
      rsp1_result_d = rsp1_result_q;
      case (state_q)
         IDLE: begin
            if (acc) begin
               last_grant_d = acc_id;
               if (acc_zero) begin
                  if (acc_id) begin
                     rsp1_valid_d  = 1'b1;
                     rsp1_result_d = {acc_a[31] ^ acc_b[31], 31'd0};
                  end else begin
                     rsp0_valid_d  = 1'b1;
                     rsp0_result_d = {acc_a[31] ^ acc_b[31], 31'd0};
                  end
               end else begin
                  owner_d     = acc_id;
                  mul_a_d     = acc_a;
                  mul_b_d     = acc_b;
                  mul_clear_d = 1'b1;
                  state_d     = LOAD;
               end
            end
         end
         LOAD: begin
            cnt_d   = 8'd0;
            state_d = RUN;
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               if (owner_q) begin
                  rsp1_valid_d  = 1'b1;
                  rsp1_result_d = mul_result;
               end else begin
                  rsp0_valid_d  = 1'b1;
                  rsp0_result_d = mul_result;
               end
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         mul_a_q       <= 32'd0;
         mul_b_q       <= 32'd0;
         mul_clear_q   <= 1'b0;
         rsp0_valid_q  <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp0_result_q <= 32'd0;
         rsp1_result_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         mul_clear_q   <= mul_clear_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp1_result_q <= rsp1_result_d;
      end
   end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter and sequencer that shares one iterative single-precision floating-point multiplier between two requesters. It accepts operand pairs through valid/ready handshakes and applies the granted pair to the shared multiplier. It clears the multiplier, waits the multiplier's fixed iteration latency, then returns the sampled result to the originating requester as a one-cycle response pulse. It sits between client blocks and the multiplier, which has no start/done handshake of its own.

## Interface
- `LATENCY`, default 25: clock cycles from multiplier clear release to a valid `mul_result`; range 1..255.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_a`, `req0_b`  in  32 each  IEEE-754 single operands, requester 0.
- `req0_ready`  out  1  requester 0 pair accepted this cycle if valid.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `rsp0_valid`  out  1  one-cycle pulse; `rsp0_result` is valid.
- `rsp0_result`  out  32  product for requester 0, held until the next rsp0 pulse.
- `rsp1_valid`, `rsp1_result`: same as rsp0, for requester 1.
- `mul_a`, `mul_b`  out  32 each  operands driven to the shared multiplier.
- `mul_clear`  out  1  drives the multiplier's reset input.
- `mul_result`  in  32  multiplier output.

## Operation
- FSM states:
  - IDLE: may accept.
  - LOAD: one cycle, `mul_clear`=1.
  - RUN: count LATENCY cycles.
- Arbitration:
  - In IDLE, `reqN_ready` is high only for the granted requester. This is combinational from `reqN_valid` and `last_grant`.
  - Only one valid: that requester is granted.
  - Both valid: grant the one not equal to `last_grant`.
  - Outside IDLE, both readies are 0.
- Accept (valid && ready at an edge in IDLE):
  - Register operands into `mul_a`/`mul_b`.
  - Record owner; set `last_grant` = owner.
  - Go to LOAD.
- LOAD → RUN: counter = 0.
- RUN: counter increments each cycle. At the edge where counter == LATENCY-1:
  - Capture `mul_result` into `rspN_result` of the owner.
  - Pulse `rspN_valid`.
  - Return to IDLE.
- `mul_a`/`mul_b` are stable from accept until the next accept.
- No back-pressure on responses: the requester must sample during the pulse.
- Requesters must hold valid and operands until ready. Deasserting valid before grant withdraws the request with no side effect.
- Reset values:
  - All outputs 0; `mul_clear` = 0.
  - state IDLE, counter 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
- Reset mid-operation: the in-flight operation is dropped and no response is issued. Both requesters see ready again from the cycle after reset deasserts.

## Timing
- Accept at edge E0 → LOAD (E0..E1) → RUN from E1 → response registered at edge E(1+LATENCY), visible for exactly one cycle.
- Latency: accept to `rsp_valid` = LATENCY+1 cycles.
- IDLE is re-entered in the same cycle `rsp_valid` is high, so a new accept can occur at that cycle's ending edge.
- Throughput: one operation per LATENCY+2 cycles.
- `mul_clear` is high exactly one cycle per operation, with operands already stable on `mul_a`/`mul_b`.
- `rsp0_valid` and `rsp1_valid` are never high in the same cycle.

## Configuration
- `FP_MUL_ARB_ZERO_BYPASS_EN` defined:
  - At accept, if `a[30:0]==0` or `b[30:0]==0`, the multiplier is not used.
  - `rspN_result` = {a[31]^b[31], 31'b0} and `rspN_valid` pulses in the cycle after accept.
  - FSM stays IDLE; `mul_a`, `mul_b` and `mul_clear` are unchanged.
  - `last_grant` still updates.
  - Caveat: zero × infinity returns signed zero, not NaN; clients must not rely on NaN for that case.
- Not defined: every request, zero or not, takes the full multiplier path.

## Test plan
- Single op, LATENCY=25: req0 2.0×3.0 (0x40000000, 0x40400000) → rsp0_valid exactly 26 cycles after accept, rsp0_result 0x40C00000; `mul_clear` high exactly one cycle.
- Tie: both valid from the same cycle after reset (req0 1.5×1.5 = 0x3FC00000², req1 2.0×2.0) → req0 served first with 0x40100000; req1 accepted in rsp0's cycle, returns 0x40800000; next tie grants req0.
- Starvation check: both valid continuously for 6 operations → grants strictly alternate 0,1,0,1,0,1; no two rsp pulses in one cycle.
- Withdrawal: req1_valid asserted while busy, dropped before IDLE → no req1 accept, no rsp1 pulse, `last_grant` unchanged.
- Reset in RUN at counter 10 → no response pulse; all outputs 0 next cycle; a fresh req0 op completes normally with correct latency.
- With `FP_MUL_ARB_ZERO_BYPASS_EN`: req0 0x80000000 × 0x40400000 → rsp0 one cycle after accept, result 0x80000000, `mul_clear` never asserted. Without the macro: same result after 26 cycles.
